// File: rtl/imm_pkg.sv
// Shared immediate type codes, skid-buffer states and base-ISA opcode constants
// for the immediate generation stage.
package imm_pkg;

  // Codes 110/111 carry no immediate format; auto-decode reports 111 for them.
  typedef enum logic [2:0] {
    IMM_I    = 3'b000,
    IMM_S    = 3'b001,
    IMM_B    = 3'b010,
    IMM_U    = 3'b011,
    IMM_J    = 3'b100,
    IMM_Z    = 3'b101,
    IMM_ILL6 = 3'b110,
    IMM_ILL  = 3'b111
  } imm_type_e;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_HALF  = 2'b01,
    ST_FULL  = 2'b10
  } skid_state_e;

  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_IMM32  = 7'b0011011;

  function automatic logic imm_type_legal(input imm_type_e t);
    case (t)
      IMM_I, IMM_S, IMM_B, IMM_U, IMM_J, IMM_Z: return 1'b1;
      default:                                  return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/imm_extract.sv
// Combinational opcode decode and immediate extraction/extension for one
// 32-bit instruction word.
module imm_extract
  import imm_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter bit AUTO_DECODE = 1'b1
) (
  input  logic [31:0]     i_instr,
  input  logic [2:0]      i_imm_sel,
  output logic [XLEN-1:0] o_imm,
  output logic [2:0]      o_type,
  output logic            o_illegal
);

  logic [6:0] w_opcode;
  imm_type_e  w_type_auto;
  imm_type_e  w_type;
  logic       w_sign;

  assign w_opcode = i_instr[6:0];
  assign w_sign   = i_instr[31];

  always_comb begin
    w_type_auto = IMM_ILL;
    case (w_opcode)
      OP_IMM, OP_LOAD, OP_JALR: w_type_auto = IMM_I;
      OP_STORE:                 w_type_auto = IMM_S;
      OP_BRANCH:                w_type_auto = IMM_B;
      OP_LUI, OP_AUIPC:         w_type_auto = IMM_U;
      OP_JAL:                   w_type_auto = IMM_J;
      // funct3[2] separates the immediate CSR forms (rs1 field is a uimm).
      OP_SYSTEM: begin
        if (i_instr[14]) begin
          w_type_auto = IMM_Z;
        end else begin
          w_type_auto = IMM_I;
        end
      end
      OP_IMM32: begin
        if (XLEN == 64) begin
          w_type_auto = IMM_I;
        end else begin
          w_type_auto = IMM_ILL;
        end
      end
      default:                  w_type_auto = IMM_ILL;
    endcase
  end

  always_comb begin
    w_type = IMM_ILL;
    if (AUTO_DECODE) begin
      w_type = w_type_auto;
    end else begin
      w_type = imm_type_e'(i_imm_sel);
    end
  end

  always_comb begin
    o_imm = '0;
    case (w_type)
      IMM_I: o_imm = {{(XLEN-12){w_sign}}, i_instr[31:20]};
      IMM_S: o_imm = {{(XLEN-12){w_sign}}, i_instr[31:25], i_instr[11:7]};
      IMM_B: o_imm = {{(XLEN-13){w_sign}}, i_instr[31], i_instr[7],
                      i_instr[30:25], i_instr[11:8], 1'b0};
      IMM_U: o_imm = {{(XLEN-31){w_sign}}, i_instr[30:12], 12'h000};
      IMM_J: o_imm = {{(XLEN-21){w_sign}}, i_instr[31], i_instr[19:12],
                      i_instr[20], i_instr[30:21], 1'b0};
      IMM_Z: o_imm = {{(XLEN-5){1'b0}}, i_instr[19:15]};
      default: o_imm = '0;
    endcase
  end

  assign o_type    = w_type;
  assign o_illegal = ~imm_type_legal(w_type);

endmodule

// File: rtl/imm_gen_stage_chk.sv
// Structural invariants of the skid buffer: the registered handshake flags
// must always agree with the buffer occupancy state.
module imm_gen_stage_chk
  import imm_pkg::*;
(
  input logic        clk,
  input logic        rst,
  input skid_state_e state,
  input logic        in_ready,
  input logic        out_valid
);

  a_ready_vs_state: assert property (@(posedge clk) disable iff (rst)
    in_ready == (state != ST_FULL));

  a_valid_vs_state: assert property (@(posedge clk) disable iff (rst)
    out_valid == (state != ST_EMPTY));

  a_state_legal: assert property (@(posedge clk) disable iff (rst)
    state inside {ST_EMPTY, ST_HALF, ST_FULL});

endmodule

// File: rtl/imm_gen_stage.sv
// Immediate generation pipeline stage: decode/extract on the input side, then a
// two-entry skid buffer (output register + skid register) with registered in_ready.
module imm_gen_stage
  import imm_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter bit AUTO_DECODE = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [2:0]      in_imm_sel,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_imm,
  output logic [2:0]      out_type,
  output logic            out_illegal,
  output logic [31:0]     out_instr
);

  logic [XLEN-1:0] w_imm;
  logic [2:0]      w_type;
  logic            w_illegal;
  logic            w_accept;
  logic            w_pop;

  skid_state_e     r_state;
  logic            r_in_ready;
  logic            r_out_valid;
  logic [XLEN-1:0] r_out_imm;
  logic [2:0]      r_out_type;
  logic            r_out_illegal;
  logic [31:0]     r_out_instr;
  logic [XLEN-1:0] r_skid_imm;
  logic [2:0]      r_skid_type;
  logic            r_skid_illegal;
  logic [31:0]     r_skid_instr;

  imm_extract #(
    .XLEN        (XLEN),
    .AUTO_DECODE (AUTO_DECODE)
  ) u_extract (
    .i_instr   (in_instr),
    .i_imm_sel (in_imm_sel),
    .o_imm     (w_imm),
    .o_type    (w_type),
    .o_illegal (w_illegal)
  );

  assign w_accept = in_valid & r_in_ready;
  assign w_pop    = r_out_valid & out_ready;

  // Flush outranks accept and pop; the skid entry only exists in FULL.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= ST_EMPTY;
      r_in_ready     <= 1'b1;
      r_out_valid    <= 1'b0;
      r_out_imm      <= '0;
      r_out_type     <= 3'b000;
      r_out_illegal  <= 1'b0;
      r_out_instr    <= 32'h0000_0000;
      r_skid_imm     <= '0;
      r_skid_type    <= 3'b000;
      r_skid_illegal <= 1'b0;
      r_skid_instr   <= 32'h0000_0000;
    end else if (flush) begin
      r_state        <= ST_EMPTY;
      r_in_ready     <= 1'b1;
      r_out_valid    <= 1'b0;
      r_out_imm      <= '0;
      r_out_type     <= 3'b000;
      r_out_illegal  <= 1'b0;
      r_out_instr    <= 32'h0000_0000;
      r_skid_imm     <= '0;
      r_skid_type    <= 3'b000;
      r_skid_illegal <= 1'b0;
      r_skid_instr   <= 32'h0000_0000;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_accept) begin
            r_out_imm     <= w_imm;
            r_out_type    <= w_type;
            r_out_illegal <= w_illegal;
            r_out_instr   <= in_instr;
            r_out_valid   <= 1'b1;
            r_state       <= ST_HALF;
          end
        end
        ST_HALF: begin
          case ({w_accept, w_pop})
            2'b10: begin
              r_skid_imm     <= w_imm;
              r_skid_type    <= w_type;
              r_skid_illegal <= w_illegal;
              r_skid_instr   <= in_instr;
              r_in_ready     <= 1'b0;
              r_state        <= ST_FULL;
            end
            2'b01: begin
              r_out_valid <= 1'b0;
              r_state     <= ST_EMPTY;
            end
            2'b11: begin
              r_out_imm     <= w_imm;
              r_out_type    <= w_type;
              r_out_illegal <= w_illegal;
              r_out_instr   <= in_instr;
            end
            default: begin
              r_state <= ST_HALF;
            end
          endcase
        end
        ST_FULL: begin
          if (w_pop) begin
            r_out_imm     <= r_skid_imm;
            r_out_type    <= r_skid_type;
            r_out_illegal <= r_skid_illegal;
            r_out_instr   <= r_skid_instr;
            r_in_ready    <= 1'b1;
            r_state       <= ST_HALF;
          end
        end
        default: begin
          r_state     <= ST_EMPTY;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready    = r_in_ready;
  assign out_valid   = r_out_valid;
  assign out_imm     = r_out_imm;
  assign out_type    = r_out_type;
  assign out_illegal = r_out_illegal;
  assign out_instr   = r_out_instr;

  imm_gen_stage_chk u_chk (
    .clk       (clk),
    .rst       (rst),
    .state     (r_state),
    .in_ready  (r_in_ready),
    .out_valid (r_out_valid)
  );

endmodule

// File: doc/imm_gen_stage.md
IMM_GEN_STAGE -- requirements
Module: imm_gen_stage

Interface
REQ-001 SHALL have parameter XLEN, default 32, immediate width; legal values are 32 and 64.
REQ-002 SHALL have parameter AUTO_DECODE, default 1; 1 means the immediate type is derived from the opcode, 0 means it is taken from in_imm_sel.
REQ-003 SHALL have port clk  input  1  single clock; all state is rising-edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port flush  input  1  synchronous pipeline flush.
REQ-006 SHALL have port in_valid  input  1  upstream instruction valid.
REQ-007 SHALL have port in_ready  output  1  stage can accept an instruction.
REQ-008 SHALL have port in_instr  input  32  instruction word.
REQ-009 SHALL have port in_imm_sel  input  3  external type select; ignored when AUTO_DECODE=1.
REQ-010 SHALL have port out_valid  output  1  result valid.
REQ-011 SHALL have port out_ready  input  1  downstream accepts the result.
REQ-012 SHALL have port out_imm  output  XLEN  extended immediate.
REQ-013 SHALL have port out_type  output  3  resolved type code.
REQ-014 SHALL have port out_illegal  output  1  no legal immediate format.
REQ-015 SHALL have port out_instr  output  32  instruction passed through.

Function
REQ-016 SHALL use type codes I=000, S=001, B=010, U=011, J=100, Z=101; codes 110 and 111 are illegal.
REQ-017 SHALL extract the immediate as follows.
- I: sign-extend instr[31:20].
- S: sign-extend {instr[31:25], instr[11:7]}.
- B: sign-extend {instr[31], instr[7], instr[30:25], instr[11:8], 0}.
- J: sign-extend {instr[31], instr[19:12], instr[20], instr[30:21], 0}.
- Z: zero-extend instr[19:15].
REQ-018 SHALL form U as {instr[31:12], 12'b0}, sign-extended from bit 31 when XLEN=64.
REQ-019 SHALL, when AUTO_DECODE=1, map the opcode to a type as follows.
- I: 0010011, 0000011, 1100111.
- S: 0100011.
- B: 1100011.
- U: 0110111, 0010111.
- J: 1101111.
- 1110011: Z when funct3[2]=1, else I.
- 0011011: I when XLEN=64, else illegal.
- All other opcodes: illegal.
REQ-020 SHALL, for an illegal type, drive out_imm=0 and out_illegal=1 with that entry, and SHALL still pass it through the handshake.
REQ-021 SHALL accept an instruction when in_valid && in_ready, and SHALL pop the output entry when out_valid && out_ready.
REQ-022 SHALL implement a 2-entry skid buffer with states EMPTY, HALF and FULL.
REQ-023 SHALL drive in_ready = (state != FULL), registered and independent of out_ready.
REQ-024 SHALL have latency 1: an instruction accepted at edge N appears on the outputs after edge N when the buffer is not blocked.
REQ-025 SHALL make these state transitions.
- EMPTY + accept -> HALF.
- HALF + accept without pop -> FULL.
- HALF + pop without accept -> EMPTY.
- HALF + accept and pop -> HALF.
- FULL + pop -> HALF, with the skid entry moving to the output.
REQ-026 SHALL keep out_* stable while out_valid=1 and out_ready=0.
REQ-027 SHALL preserve acceptance order with no loss and no duplication.
REQ-028 SHALL, on flush=1 at an edge, go to EMPTY and discard both entries and any same-cycle input; out_valid=0 and in_ready=1 after that edge.
REQ-029 SHALL give flush priority over accept and pop in the same cycle.

Reset
REQ-030 SHALL, on rst=1 and asynchronously, set state=EMPTY, out_valid=0, in_ready=1, out_imm=0, out_type=0, out_illegal=0 and out_instr=0.
REQ-031 SHALL, on rst mid-transfer, drop all buffered entries; the first accept after rst deasserts behaves as from EMPTY.

Structure
REQ-032 SHALL place the type-code enum imm_type_e and the opcode constants in shared package imm_pkg.
REQ-033 SHALL implement opcode decode and extraction in a combinational sub-module imm_extract (parameter XLEN), instantiated once on the input side.

Verification
REQ-034 SHALL cover: XLEN=32, 0xFFF00093 (addi x1,x0,-1) -> one cycle later out_imm=0xFFFFFFFF, out_type=000.
REQ-035 SHALL cover: 0xFE112E23 (sw x1,-4(x2)) -> out_imm=0xFFFFFFFC, type 001; 0x3405D073 (csrrwi) -> out_imm=0x0000000B, type 101.
REQ-036 SHALL cover: XLEN=64, 0x800002B7 (lui) -> out_imm=0xFFFFFFFF80000000, type 011; 0x123452B7 -> 0x0000000012345000.
REQ-037 SHALL cover: out_ready=0 while three instructions are offered -> two accepted, in_ready=0 after the second; then out_ready=1 -> outputs in order, third accepted.
REQ-038 SHALL cover: flush while FULL with in_valid=1 -> next cycle out_valid=0, in_ready=1, nothing from before the flush is emitted.
REQ-039 SHALL cover: 0x00000000 -> out_illegal=1, out_imm=0; rst asserted mid-stream -> outputs cleared immediately, without waiting for a clock edge.
